// File: rtl/puf_response_collector.sv
// Sequences RESP_BITS arbiter races (clear, race, capture) and shifts each winner bit into a response word.
// Each bit costs SETTLE_CYCLES + D + 1 cycles; the word is held on resp_valid until resp_ready, with no new request accepted meanwhile.
module puf_response_collector #(
  parameter int RESP_BITS      = 32,
  parameter int CHAL_WIDTH     = 8,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CHAL_WIDTH-1:0] challenge_seed,
  output logic [CHAL_WIDTH-1:0] chal,
  output logic                  race_reset,
  input  logic                  arb_done,
  input  logic                  arb_out,
  output logic                  busy,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [RESP_BITS-1:0]  resp_data,
  output logic                  timeout_err
);

  localparam int BIT_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(RESP_BITS - 1);
  localparam logic [SET_W-1:0] SETTLE_END = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_END     = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, RACE, CAPTURE, PRESENT} state_t;

  state_t           state;
  logic [BIT_W-1:0] bit_idx;
  logic [SET_W-1:0] settle_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             timed_out;
  logic             done_meta, done_s;
  logic             out_meta, out_s;
  logic             cap_bit;

  // A timed-out race contributes 0 regardless of whatever the arbiter shows.
  assign cap_bit = out_s & ~timed_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      race_reset  <= 1'b1;
      chal        <= '0;
      busy        <= 1'b0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      timeout_err <= 1'b0;
      bit_idx     <= '0;
      settle_cnt  <= '0;
      to_cnt      <= '0;
      timed_out   <= 1'b0;
      done_meta   <= 1'b0;
      done_s      <= 1'b0;
      out_meta    <= 1'b0;
      out_s       <= 1'b0;
    end else begin
      done_meta <= arb_done;
      done_s    <= done_meta;
      out_meta  <= arb_out;
      out_s     <= out_meta;

      case (state)
        IDLE: begin
          if (start) begin
            chal        <= challenge_seed;
            bit_idx     <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            settle_cnt  <= '0;
            race_reset  <= 1'b1;
            state       <= CLEAR;
          end
        end
        CLEAR: begin
          if (settle_cnt == SETTLE_END) begin
            race_reset <= 1'b0;
            to_cnt     <= '0;
            timed_out  <= 1'b0;
            state      <= RACE;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        RACE: begin
          // done_s is checked first so a result landing on the last allowed cycle still counts.
          if (done_s) begin
            state <= CAPTURE;
          end else if (to_cnt == TO_END) begin
            timed_out   <= 1'b1;
            timeout_err <= 1'b1;
            state       <= CAPTURE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        CAPTURE: begin
          resp_data  <= RESP_BITS'({resp_data, cap_bit});
          race_reset <= 1'b1;
          bit_idx    <= bit_idx + BIT_W'(1);
          chal       <= chal + CHAL_WIDTH'(1);
          settle_cnt <= '0;
          if (bit_idx == LAST_BIT) begin
            resp_valid <= 1'b1;
            state      <= PRESENT;
          end else begin
            state <= CLEAR;
          end
        end
        PRESENT: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
